alu_seq_exec: RTL

Parametrised successor to the core's combinational ALU opcode controller. Decodes ALU mode and `{funct7[5], funct3}` into a full RV32I integer operation set and executes it with an iterative, step-configurable shifter. Results are registered behind a valid/ready handshake, so the execute stage can stall on multi-cycle shifts. Sits between the decode/issue logic and the writeback/branch-resolve path.

---
 rtl/alu_pkg.sv | 66 ++++++
 rtl/alu_iter_shifter.sv | 61 ++++++
 rtl/alu_seq_exec.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for alu_seq_exec: ALU modes, {funct7[5], funct3} codes,
// the internal operation enum, FSM states and the funct decoder.
package alu_pkg;

    localparam logic [1:0] ALU_MODE_ADD = 2'b00;
    localparam logic [1:0] ALU_MODE_SUB = 2'b01;
    localparam logic [1:0] ALU_MODE_R   = 2'b10;
    localparam logic [1:0] ALU_MODE_I   = 2'b11;

    localparam logic [3:0] FUNCT_ADD  = 4'b0000;
    localparam logic [3:0] FUNCT_SUB  = 4'b1000;
    localparam logic [3:0] FUNCT_SLL  = 4'b0001;
    localparam logic [3:0] FUNCT_SLT  = 4'b0010;
    localparam logic [3:0] FUNCT_SLTU = 4'b0011;
    localparam logic [3:0] FUNCT_XOR  = 4'b0100;
    localparam logic [3:0] FUNCT_SRL  = 4'b0101;
    localparam logic [3:0] FUNCT_SRA  = 4'b1101;
    localparam logic [3:0] FUNCT_OR   = 4'b0110;
    localparam logic [3:0] FUNCT_AND  = 4'b0111;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ILLEGAL
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    function automatic alu_op_e decode_op(input logic [1:0] mode, input logic [3:0] funct);
        alu_op_e    op;
        logic [3:0] code;
        op   = OP_ILLEGAL;
        code = funct;
        case (mode)
            ALU_MODE_ADD: op = OP_ADD;
            ALU_MODE_SUB: op = OP_SUB;
            default: begin
                // I-type drops funct7[5] except on right shifts; 1001 (SLLI with funct7[5]) maps to an unused code.
                if (mode == ALU_MODE_I) begin
                    if (funct == 4'b1001)
                        code = 4'b1111;
                    else if (funct[2:0] != 3'b101)
                        code = {1'b0, funct[2:0]};
                end
                case (code)
                    FUNCT_ADD:  op = OP_ADD;
                    FUNCT_SUB:  op = OP_SUB;
                    FUNCT_SLL:  op = OP_SLL;
                    FUNCT_SLT:  op = OP_SLT;
                    FUNCT_SLTU: op = OP_SLTU;
                    FUNCT_XOR:  op = OP_XOR;
                    FUNCT_SRL:  op = OP_SRL;
                    FUNCT_SRA:  op = OP_SRA;
                    FUNCT_OR:   op = OP_OR;
                    FUNCT_AND:  op = OP_AND;
                    default:    op = OP_ILLEGAL;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative shifter: moves the working register by up to SHIFT_STEP bits per cycle.
// data_out is the post-step value so the final step can land directly in a result register.
module alu_iter_shifter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     dir,
    input  logic                     arith,
    input  logic [$clog2(XLEN)-1:0]  amount,
    input  logic [XLEN-1:0]          data_in,
    output logic                     busy,
    output logic [XLEN-1:0]          data_out
);
    localparam int unsigned   AW   = $clog2(XLEN);
    localparam logic [AW:0]   STEP = (AW+1)'(SHIFT_STEP);

    logic [XLEN-1:0] work_q;
    logic [AW-1:0]   remaining_q;
    logic            dir_q;
    logic            arith_q;
    logic [AW:0]     remaining_ext;
    logic [AW:0]     step_amt;

    assign remaining_ext = {1'b0, remaining_q};
    assign step_amt      = (remaining_ext < STEP) ? remaining_ext : STEP;
    // Busy only while more than the current step is left, so the caller sees the last step coming.
    assign busy          = (remaining_ext > STEP);

    always_comb begin
        data_out = work_q << step_amt;
        if (dir_q) begin
            if (arith_q)
                data_out = $signed(work_q) >>> step_amt;
            else
                data_out = work_q >> step_amt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q      <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            arith_q     <= 1'b0;
        end else if (start) begin
            work_q      <= data_in;
            remaining_q <= amount;
            dir_q       <= dir;
            arith_q     <= arith;
        end else if (remaining_q != '0) begin
            work_q      <= data_out;
            remaining_q <= remaining_q - step_amt[AW-1:0];
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// RV32I-style integer ALU with registered result behind a valid/ready handshake;
// shifts run through the iterative shifter, everything else completes on the accept edge.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_mode,
    input  logic [3:0]      funct,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int unsigned AW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    alu_op_e         op_dec;
    logic [AW-1:0]   shamt;
    logic            is_shift;
    logic [XLEN-1:0] alu_res;
    logic            shift_start;
    logic            shift_busy;
    logic [XLEN-1:0] shift_out;

    assign op_dec   = decode_op(alu_mode, funct);
    assign shamt    = op_b[AW-1:0];
    assign is_shift = (op_dec == OP_SLL) || (op_dec == OP_SRL) || (op_dec == OP_SRA);

    always_comb begin
        alu_res = '0;
        case (op_dec)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            // Shifts only complete here when the amount is zero.
            OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
            default: alu_res = '0;
        endcase
    end

    alu_iter_shifter #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .start    (shift_start),
        .dir      (op_dec != OP_SLL),
        .arith    (op_dec == OP_SRA),
        .amount   (shamt),
        .data_in  (op_a),
        .busy     (shift_busy),
        .data_out (shift_out)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        shift_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        shift_start = 1'b1;
                        state_d     = ST_SHIFT;
                    end else begin
                        state_d   = ST_DONE;
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = (op_dec == OP_ILLEGAL);
                    end
                end
            end
            ST_SHIFT: begin
                if (!shift_busy) begin
                    state_d   = ST_DONE;
                    result_d  = shift_out;
                    zero_d    = (shift_out == '0);
                    illegal_d = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
